sobel_magnitude: RTL and testbench



---
 rtl/sobel_magnitude.sv | 113 +++++++++++
 tb/tb_sobel_magnitude.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sobel_magnitude.sv
// sobel_magnitude: streams GX/GY RAMs and writes saturated |GX|+|GY| per pixel to M_RAM (MAG_THRESHOLD_EN selects a binary edge map)
module sobel_magnitude #(
  parameter int width      = 8,
  parameter int depth_bits = 14,
  parameter int num_pixels = 15876,
  parameter int THRESHOLD  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  output logic                  Done,
  output logic                  GX_read_en,
  output logic [depth_bits-1:0] GX_read_address,
  input  logic [width-1:0]      GX_read_data_out,
  output logic                  GY_read_en,
  output logic [depth_bits-1:0] GY_read_address,
  input  logic [width-1:0]      GY_read_data_out,
  output logic                  M_write_en,
  output logic [depth_bits-1:0] M_write_address,
  output logic [width-1:0]      M_write_data_in
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [depth_bits-1:0] LAST_ADDR = depth_bits'(num_pixels - 1);
`ifdef MAG_THRESHOLD_EN
  localparam bit thr_en = 1'b1;
`else
  localparam bit thr_en = 1'b0;
`endif
  logic [1:0]            state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [depth_bits-1:0] rd_addr_q, rd_addr_d;
  logic                  s0_valid_q, s0_valid_d;
  logic [depth_bits-1:0] s0_addr_q, s0_addr_d;
  logic                  we_q, we_d;
  logic [depth_bits-1:0] waddr_q, waddr_d;
  logic [width-1:0]      wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic [width:0]        gx_ext, gy_ext, abs_gx, abs_gy;
  logic [width+1:0]      sum;
  logic [width-1:0]      sat, mag;
  assign Done            = done_q;
  assign GX_read_en      = rd_en_q;
  assign GY_read_en      = rd_en_q;
  assign GX_read_address = rd_addr_q;
  assign GY_read_address = rd_addr_q;
  assign M_write_en      = we_q;
  assign M_write_address = waddr_q;
  assign M_write_data_in = wdata_q;
  // magnitude datapath, FSM and pipeline next-state
  always_comb begin
    gx_ext     = {GX_read_data_out[width-1], GX_read_data_out};
    gy_ext     = {GY_read_data_out[width-1], GY_read_data_out};
    abs_gx     = gx_ext[width] ? -gx_ext : gx_ext;
    abs_gy     = gy_ext[width] ? -gy_ext : gy_ext;
    sum        = {1'b0, abs_gx} + {1'b0, abs_gy};
    sat        = (sum > (width+2)'((1 << width) - 1)) ? '1 : sum[width-1:0];
    mag        = !thr_en ? sat : (sat >= width'(THRESHOLD)) ? '1 : '0;
    state_d    = state_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    done_d     = 1'b0;
    s0_valid_d = rd_en_q;
    s0_addr_d  = rd_addr_q;
    we_d       = s0_valid_q;
    waddr_d    = s0_valid_q ? s0_addr_q : waddr_q;
    wdata_d    = s0_valid_q ? mag : wdata_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d   = RUN;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
      end
      RUN: if (rd_addr_q == LAST_ADDR) begin
        state_d = DRAIN;
        rd_en_d = 1'b0;
      end else begin
        rd_addr_d = rd_addr_q + depth_bits'(1);
      end
      DRAIN: if (!s0_valid_q && we_q) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      s0_valid_q <= 1'b0;
      s0_addr_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      s0_valid_q <= s0_valid_d;
      s0_addr_q  <= s0_addr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_sobel_magnitude.sv
// tb_sobel_magnitude: directed checks of sobel_magnitude timing, arithmetic, Start handling and reset abort
module tb_sobel_magnitude;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;
  logic        done, gxen, gyen, we;
  logic [13:0] gxa, gya, wa;
  logic [7:0]  gxd, gyd, wd;
  logic [7:0]  gx_mem [0:15];
  logic [7:0]  gy_mem [0:15];
  logic        done_b, gxen_b, gyen_b, we_b;
  logic [13:0] gxa_b, gya_b, wa_b;
  logic [7:0]  gxd_b, gyd_b, wd_b;
  int n_tests = 0, n_fail = 0;
  int we_a [0:31], wa_a [0:31], wd_a [0:31], dn_a [0:31], en_a [0:31], ra_a [0:31], same_a [0:31];
  sobel_magnitude #(.num_pixels(4)) dut (
    .clk(clk), .rst(rst), .Start(start), .Done(done),
    .GX_read_en(gxen), .GX_read_address(gxa), .GX_read_data_out(gxd),
    .GY_read_en(gyen), .GY_read_address(gya), .GY_read_data_out(gyd),
    .M_write_en(we), .M_write_address(wa), .M_write_data_in(wd)
  );
  sobel_magnitude dut_b (
    .clk(clk), .rst(rst), .Start(start_b), .Done(done_b),
    .GX_read_en(gxen_b), .GX_read_address(gxa_b), .GX_read_data_out(gxd_b),
    .GY_read_en(gyen_b), .GY_read_address(gya_b), .GY_read_data_out(gyd_b),
    .M_write_en(we_b), .M_write_address(wa_b), .M_write_data_in(wd_b)
  );
  // synchronous-read RAM models
  always @(posedge clk) begin
    if (gxen) gxd <= gx_mem[gxa[3:0]];
    if (gyen) gyd <= gy_mem[gya[3:0]];
    if (gxen_b) gxd_b <= gxa_b[7:0];
    if (gyen_b) gyd_b <= gya_b[13:6];
  end
  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction
  function automatic int ref_mag(input logic [7:0] gx, input logic [7:0] gy);
    int s;
    s = iabs(int'($signed(gx))) + iabs(int'($signed(gy)));
    if (s > 255) s = 255;
`ifdef MAG_THRESHOLD_EN
    return s >= 64 ? 255 : 0;
`else
    return s;
`endif
  endfunction
  function automatic int cnt(input int which, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += (which == 0) ? we_a[i] : dn_a[i];
    return n;
  endfunction
  // called at a negedge; Start is high during offset 0, samples taken at offsets 1..ncyc
  task automatic go(input int ncyc, input bit hold, input int again, input int rst_at);
    start = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      we_a[i] = int'(we); wa_a[i] = int'(wa); wd_a[i] = int'(wd); dn_a[i] = int'(done);
      en_a[i] = int'(gxen); ra_a[i] = int'(gxa);
      same_a[i] = int'(gxen == gyen && gxa == gya);
      if (!hold) start = (i == again);
      rst = (i == rst_at);
    end
  endtask
  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int exp1 [0:3] = '{8, 255, 200, 0};
`ifdef MAG_THRESHOLD_EN
    int exp2 [0:3] = '{0, 255, 0, 255};
`else
    int exp2 [0:3] = '{63, 64, 0, 255};
`endif
    int idx, addr_err, data_err, n_we, n_dn, dn_off;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_done", int'(done), 0);
    check("reset_outputs", int'({gxen, gyen, we, gxa, gya, wa, wd}), 0);
    rst = 1'b0;
    @(negedge clk);
    gx_mem[0] = 8'd3;   gy_mem[0] = 8'hFB;
    gx_mem[1] = 8'h80;  gy_mem[1] = 8'h80;
    gx_mem[2] = 8'd100; gy_mem[2] = 8'd100;
    gx_mem[3] = 8'd0;   gy_mem[3] = 8'd0;
    go(10, 1'b0, 0, 0);
    check("t1_first_rd_en", en_a[1], 1);
    check("t1_first_rd_addr", ra_a[1], 0);
    check("t1_last_rd_addr", ra_a[4], 3);
    check("t1_rd_en_off", en_a[5], 0);
    for (int i = 1; i <= 10; i++) check("t1_gx_gy_same", same_a[i], 1);
    check("t1_no_early_write", we_a[2], 0);
`ifndef MAG_THRESHOLD_EN
    for (int k = 0; k < 4; k++) begin
      check("t1_we", we_a[3+k], 1);
      check("t1_addr", wa_a[3+k], k);
      check("t1_data", wd_a[3+k], exp1[k]);
    end
`endif
    check("t1_write_count", cnt(0, 1, 10), 4);
    check("t1_done_at_7", dn_a[7], 1);
    check("t1_done_count", cnt(1, 1, 10), 1);
    idle(2);
    gx_mem[0] = 8'd63;  gy_mem[0] = 8'd0;
    gx_mem[1] = 8'd64;  gy_mem[1] = 8'd0;
    gx_mem[2] = 8'd0;   gy_mem[2] = 8'd0;
    gx_mem[3] = 8'd127; gy_mem[3] = 8'h80;
    go(10, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("t2_addr", wa_a[3+k], k);
      check("t2_data", wd_a[3+k], exp2[k]);
    end
    check("t2_done_at_7", dn_a[7], 1);
    idle(2);
    go(20, 1'b1, 0, 0);
    check("t3_done_run1", dn_a[7], 1);
    check("t3_rd_en_idle", en_a[8], 0);
    check("t3_run2_rd_en", en_a[9], 1);
    check("t3_run2_rd_addr", ra_a[9], 0);
    check("t3_gap_no_write", cnt(0, 7, 10), 0);
    check("t3_run2_first_we", we_a[11], 1);
    check("t3_run2_first_addr", wa_a[11], 0);
    check("t3_done_run2", dn_a[15], 1);
    check("t3_done_count", cnt(1, 1, 20), 2);
    check("t3_write_count", cnt(0, 1, 20), 10);
    idle(12);
    go(10, 1'b0, 2, 0);
    check("t4_write_count", cnt(0, 1, 10), 4);
    check("t4_done_count", cnt(1, 1, 10), 1);
    check("t4_done_at_7", dn_a[7], 1);
    check("t4_no_restart", en_a[9], 0);
    idle(2);
    go(10, 1'b0, 0, 3);
    check("t5_write_before_rst", we_a[3], 1);
    check("t5_outputs_zero", int'(we_a[4] | wa_a[4] | wd_a[4] | dn_a[4] | en_a[4] | ra_a[4]), 0);
    check("t5_no_writes_after", cnt(0, 4, 10), 0);
    check("t5_no_done", cnt(1, 1, 10), 0);
    idle(2);
    go(10, 1'b0, 0, 0);
    check("t5_recover_writes", cnt(0, 1, 10), 4);
    check("t5_recover_last_addr", wa_a[6], 3);
    check("t5_recover_done", dn_a[7], 1);
    idle(2);
    idx = 0; addr_err = 0; data_err = 0; n_we = 0; n_dn = 0; dn_off = -1;
    start_b = 1'b1;
    for (int off = 1; off <= 15900; off++) begin
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      if (we_b) begin
        n_we++;
        if (int'(wa_b) != idx) addr_err++;
        if (int'(wd_b) != ref_mag(wa_b[7:0], wa_b[13:6])) data_err++;
        idx++;
      end
      if (done_b) begin
        n_dn++;
        dn_off = off;
      end
    end
    check("big_write_count", n_we, 15876);
    check("big_addr_errors", addr_err, 0);
    check("big_data_errors", data_err, 0);
    check("big_done_count", n_dn, 1);
    check("big_done_offset", dn_off, 15879);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
